// File: rtl/btn_event_conditioner.sv
// rtl/btn_event_conditioner.sv - debounced push-button level with classified press events
module btn_event_conditioner #(
  parameter int TICK_CYCLES    = 10000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int LONG_TICKS     = 200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       btn_clean,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       event_valid,
  output logic [1:0] event_code,
  input  logic       event_ack,
  output logic       overflow
);

  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int SW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] TICK_ONE    = TW'(1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_TICKS - 1);
  localparam logic [SW-1:0] STABLE_ONE  = SW'(1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] HOLD_ONE    = HW'(1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_HELD      = 2'd1;
  localparam logic [1:0] ST_LONG_HELD = 2'd2;

  localparam logic [1:0] EV_SHORT    = 2'b01;
  localparam logic [1:0] EV_LONG     = 2'b10;
  localparam logic [1:0] EV_REL_LONG = 2'b11;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;
  logic          clean_q, clean_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]    state_q, state_d;
  logic          valid_q, valid_d;
  logic [1:0]    code_q, code_d;
  logic          overflow_q, overflow_d;

  logic          tick;
  logic          btn_s;
  logic          emit;
  logic [1:0]    emit_code;

  assign btn_s = sync2_q;

  // Two-flop synchroniser for the raw button and the free-running sample-tick divider
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_ONE;
  end

  // Debounce: accept a new level only after enough consecutive differing tick samples
  always_comb begin
    clean_d      = clean_q;
    stable_cnt_d = stable_cnt_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    if (tick) begin
      if (btn_s != clean_q) begin
        if (stable_cnt_q == STABLE_LAST) begin
          clean_d      = btn_s;
          stable_cnt_d = '0;
          press_d      = btn_s;
          release_d    = ~btn_s;
        end else begin
          stable_cnt_d = stable_cnt_q + STABLE_ONE;
        end
      end else begin
        stable_cnt_d = '0;
      end
    end
  end

  // Hold duration in ticks, restarted on each accepted press and saturating at the long threshold
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (press_d) begin
      hold_cnt_d = '0;
    end else if (tick && clean_q && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + HOLD_ONE;
    end
  end

  // Press classifier; LONG fires from HELD only, so it is emitted once per press
  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_code = EV_SHORT;
    case (state_q)
      ST_IDLE: begin
        if (press_q) state_d = ST_HELD;
      end
      ST_HELD: begin
        if (release_q) begin
          state_d   = ST_IDLE;
          emit      = 1'b1;
          emit_code = EV_SHORT;
        end else if (tick && clean_q && (hold_cnt_q == HOLD_LAST)) begin
          state_d   = ST_LONG_HELD;
          emit      = 1'b1;
          emit_code = EV_LONG;
        end
      end
      ST_LONG_HELD: begin
        if (release_q) begin
          state_d   = ST_IDLE;
          emit      = 1'b1;
          emit_code = EV_REL_LONG;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One-deep event register; a full register drops new events and latches overflow
  always_comb begin
    valid_d    = valid_q;
    code_d     = code_q;
    overflow_d = overflow_q;
    if (emit) begin
      if (!valid_q || event_ack) begin
        valid_d = 1'b1;
        code_d  = emit_code;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (event_ack) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      tick_cnt_q   <= '0;
      stable_cnt_q <= '0;
      clean_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      hold_cnt_q   <= '0;
      state_q      <= ST_IDLE;
      valid_q      <= 1'b0;
      code_q       <= 2'b00;
      overflow_q   <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      tick_cnt_q   <= tick_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      clean_q      <= clean_d;
      press_q      <= press_d;
      release_q    <= release_d;
      hold_cnt_q   <= hold_cnt_d;
      state_q      <= state_d;
      valid_q      <= valid_d;
      code_q       <= code_d;
      overflow_q   <= overflow_d;
    end
  end

  assign btn_clean     = clean_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign event_valid   = valid_q;
  assign event_code    = code_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_btn_event_conditioner.sv
// tb/tb_btn_event_conditioner.sv - randomized self-checking bench with a behavioural button model
module tb_btn_event_conditioner;

  localparam int T = 4;
  localparam int D = 3;
  localparam int L = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_raw;
  logic       btn_clean;
  logic       press_pulse;
  logic       release_pulse;
  logic       event_valid;
  logic [1:0] event_code;
  logic       event_ack;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int ack_mode = 0;
  int pp_cnt = 0;

  // Behavioural model state, all plain integers
  int m_n, m_r1, m_s, m_clean, m_run, m_pp, m_rp, m_hold;
  int m_active, m_long, m_valid, m_code, m_ovf;

  btn_event_conditioner #(
    .TICK_CYCLES(T),
    .DEBOUNCE_TICKS(D),
    .LONG_TICKS(L)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_clean(btn_clean),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .event_valid(event_valid),
    .event_code(event_code),
    .event_ack(event_ack),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Event the model says is produced at the coming clock edge (0 = none)
  function automatic int model_emit_code();
    int tk;
    tk = ((m_n % T) == T - 1) ? 1 : 0;
    if (reset) return 0;
    if (m_active != 0 && m_rp != 0) return (m_long != 0) ? 3 : 1;
    if (m_active != 0 && m_long == 0 && tk != 0 && m_clean != 0 && m_hold == L - 1) return 2;
    return 0;
  endfunction

  function automatic void model_step();
    int tk, em, old_clean, new_pp, new_rp;
    if (reset) begin
      m_n = 0; m_r1 = 0; m_s = 0; m_clean = 0; m_run = 0; m_pp = 0; m_rp = 0;
      m_hold = 0; m_active = 0; m_long = 0; m_valid = 0; m_code = 0; m_ovf = 0;
      return;
    end
    tk = ((m_n % T) == T - 1) ? 1 : 0;
    em = model_emit_code();
    if (em != 0) begin
      if (m_valid == 0 || event_ack) begin
        m_valid = 1;
        m_code  = em;
      end else begin
        m_ovf = 1;
      end
    end else if (event_ack) begin
      m_valid = 0;
    end
    if (em == 2) m_long = 1;
    else if (em != 0) m_active = 0;
    else if (m_pp != 0) begin
      m_active = 1;
      m_long   = 0;
    end
    old_clean = m_clean;
    new_pp = 0;
    new_rp = 0;
    if (tk != 0) begin
      if (m_s != m_clean) begin
        if (m_run + 1 == D) begin
          m_clean = m_s;
          m_run   = 0;
          new_pp  = m_s;
          new_rp  = 1 - m_s;
        end else begin
          m_run = m_run + 1;
        end
      end else begin
        m_run = 0;
      end
    end
    if (new_pp != 0) m_hold = 0;
    else if (tk != 0 && old_clean != 0 && m_hold < L) m_hold = m_hold + 1;
    m_pp = new_pp;
    m_rp = new_rp;
    m_s  = m_r1;
    m_r1 = btn_raw ? 1 : 0;
    m_n  = m_n + 1;
  endfunction

  // One clock: choose ack, advance model, then compare every output after the edge
  task automatic cycle();
    if (ack_mode == 0) event_ack = 1'b0;
    else if (ack_mode == 1) event_ack = ($urandom_range(0, 3) == 0);
    else if (ack_mode == 2) event_ack = 1'b1;
    model_step();
    @(posedge clock);
    #1;
    check_eq("btn_clean", 32'(btn_clean), m_clean);
    check_eq("press_pulse", 32'(press_pulse), m_pp);
    check_eq("release_pulse", 32'(release_pulse), m_rp);
    check_eq("event_valid", 32'(event_valid), m_valid);
    check_eq("overflow", 32'(overflow), m_ovf);
    if (m_valid != 0) check_eq("event_code", 32'(event_code), m_code);
    pp_cnt += int'(press_pulse);
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int hit;
    reset     = 1'b1;
    btn_raw   = 1'b0;
    event_ack = 1'b0;
    @(negedge clock);
    run(3);
    reset = 1'b0;
    run(5);

    // Clean short press, held well under the long threshold
    pp_cnt  = 0;
    btn_raw = 1'b1;
    run(20);
    check_eq("clean_press_count", pp_cnt, 1);
    btn_raw = 1'b0;
    run(24);
    check_eq("short_valid", 32'(event_valid), 1);
    check_eq("short_code", 32'(event_code), 1);
    ack_mode = 2;
    run(1);
    check_eq("short_acked", 32'(event_valid), 0);
    run(3);
    ack_mode = 0;

    // Bounce: 1,0,1 on successive ticks then steady high
    pp_cnt  = 0;
    btn_raw = 1'b1; run(T);
    btn_raw = 1'b0; run(T);
    btn_raw = 1'b1; run(6 * T);
    check_eq("bounce_press_count", pp_cnt, 1);
    btn_raw = 1'b0;
    run(24);
    ack_mode = 2; run(2); ack_mode = 0;

    // Long press, acked, then release gives the release-after-long event
    btn_raw = 1'b1;
    run(14 + 12 * T);
    check_eq("long_code", 32'(event_code), 2);
    check_eq("long_valid", 32'(event_valid), 1);
    ack_mode = 2; run(2); ack_mode = 0;
    btn_raw = 1'b0;
    run(24);
    check_eq("rel_long_code", 32'(event_code), 3);
    ack_mode = 2; run(2); ack_mode = 0;

    // Overflow: long press without ack, release is dropped
    btn_raw = 1'b1;
    run(14 + 12 * T);
    btn_raw = 1'b0;
    run(24);
    check_eq("ovf_code_kept", 32'(event_code), 2);
    check_eq("ovf_flag", 32'(overflow), 1);

    // Ack exactly when a new event is emitted: new code loads, valid stays high
    btn_raw = 1'b1;
    run(30);
    btn_raw  = 1'b0;
    ack_mode = 3;
    hit = 0;
    for (int i = 0; i < 200 && hit == 0; i++) begin
      event_ack = (model_emit_code() != 0);
      hit = int'(event_ack);
      cycle();
    end
    event_ack = 1'b0;
    check_eq("ack_emit_seen", hit, 1);
    check_eq("ack_emit_code", 32'(event_code), 1);
    check_eq("ack_emit_valid", 32'(event_valid), 1);
    ack_mode = 2; run(4); ack_mode = 0;

    // Reset in the middle of a hold, button still pressed afterwards
    btn_raw = 1'b1;
    run(14 + 6 * T);
    reset = 1'b1;
    cycle();
    check_eq("rst_clean", 32'(btn_clean), 0);
    check_eq("rst_valid", 32'(event_valid), 0);
    check_eq("rst_ovf", 32'(overflow), 0);
    check_eq("rst_code", 32'(event_code), 0);
    reset  = 1'b0;
    pp_cnt = 0;
    for (int i = 0; i < 100 && pp_cnt == 0; i++) cycle();
    check_eq("repress_seen", pp_cnt, 1);
    btn_raw = 1'b0;
    run(24);
    ack_mode = 2; run(2);

    // Randomized bouncy presses with random acknowledge behaviour
    for (int seg = 0; seg < 60; seg++) begin
      ack_mode = $urandom_range(0, 2);
      btn_raw  = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) run($urandom_range(1, 6));
      else run($urandom_range(10, 70));
    end
    btn_raw  = 1'b0;
    ack_mode = 1;
    run(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_event_conditioner.md
Name: btn_event_conditioner

Overview:
- Input-side companion to the game core's slow-tick output path.
- Converts a raw, bouncy, asynchronous push-button into a debounced level and classified press events: short press, long-press reached, release after long.
- Events go through a one-deep valid/ack handshake.
- Runs on the 2 MHz system clock and uses its own internal sample-tick divider.

Parameters:
- TICK_CYCLES, 10000: clock cycles per sample tick (5 ms at 2 MHz).
- DEBOUNCE_TICKS, 4: consecutive differing tick samples required to accept a new level.
- LONG_TICKS, 200: ticks of held level that qualify as a long press (1 s).

Ports:
- clock  input  1  system clock, 2 MHz
- reset  input  1  synchronous, active-high
- btn_raw  input  1  asynchronous raw button, active-high
- btn_clean  output  1  debounced button level
- press_pulse  output  1  one-cycle strobe on btn_clean rising
- release_pulse  output  1  one-cycle strobe on btn_clean falling
- event_valid  output  1  event register holds an unconsumed event
- event_code  output  2  01 SHORT, 10 LONG, 11 RELEASE_AFTER_LONG; 00 never presented while valid
- event_ack  input  1  consumer accepts the event in the same cycle event_valid=1
- overflow  output  1  sticky: an event was dropped because the register was full

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values:
  - All outputs are 0.
  - tick_cnt, stable_cnt and hold_cnt are 0.
  - Both synchroniser flops are 0.
  - FSM state is IDLE.
- Synchroniser: btn_raw passes through 2 flops to give btn_s (2-cycle latency).
- Tick generation:
  - tick_cnt counts 0..TICK_CYCLES-1 and wraps.
  - tick=1 in the cycle where tick_cnt==TICK_CYCLES-1.
- Debounce, evaluated on tick cycles only:
  - If btn_s != btn_clean: stable_cnt increments.
  - If btn_s == btn_clean: stable_cnt clears to 0.
  - When the increment would reach DEBOUNCE_TICKS: btn_clean <= btn_s and stable_cnt <= 0.
  - One bounce that matches btn_clean on any tick restarts the count.
- Strobes:
  - press_pulse and release_pulse are registered.
  - Each is high for exactly the one cycle after btn_clean changes.
  - They are never high together.
- Hold counter:
  - Clears on the cycle btn_clean rises.
  - Increments on each tick while btn_clean=1.
  - Saturates at LONG_TICKS with no wrap.
- FSM states: IDLE, HELD, LONG_HELD.
  - IDLE -> HELD on press_pulse.
  - HELD -> LONG_HELD on the tick where hold_cnt reaches LONG_TICKS; emit LONG.
  - HELD -> IDLE on release_pulse; emit SHORT.
  - LONG_HELD -> IDLE on release_pulse; emit RELEASE_AFTER_LONG.
  - LONG is emitted exactly once per press.
- Event register:
  - An emit while event_valid=0 loads event_code and sets event_valid the next cycle.
  - An emit while event_valid=1 and event_ack=1 loads the new event; event_valid stays 1.
  - An emit while event_valid=1 and event_ack=0 drops the new event, keeps the old one, and sets overflow. Overflow clears only on reset.
  - event_ack with no emit clears event_valid the next cycle.
  - event_ack while event_valid=0 is ignored.
  - event_code holds stable while event_valid=1.
- Reset mid-press: everything returns to reset values. If btn_raw is still high, a fresh debounce produces a new press_pulse.
- Widths: each counter uses $clog2(param+1) bits. Parameters must be ≥1 (TICK_CYCLES ≥2).

Test Plan (TICK_CYCLES=4, DEBOUNCE_TICKS=3, LONG_TICKS=10 unless noted):
- Clean press: btn_raw 0->1 and held -> btn_clean rises on the 3rd tick after btn_s goes high; press_pulse is 1 cycle wide; no event yet.
- Bounce: btn_raw toggles 1,0,1 on successive ticks, then stays 1 -> btn_clean rises only after 3 consecutive high tick samples; exactly one press_pulse.
- Short press: hold for 5 ticks after btn_clean=1, then release -> release_pulse, then event_valid=1 with event_code=01. Ack clears it the next cycle.
- Long press: hold for 12 ticks -> event_code=10 on the 10th tick. After ack, releasing gives event_code=11. Exactly 2 events in total.
- Overflow: long press with no ack, then release -> event_code stays 10 and overflow=1. Acking together with a simultaneous emit loads the new code and leaves valid=1.
- Reset mid-hold: assert reset after 6 held ticks -> all outputs are 0 the next cycle. After reset deasserts with btn_raw still high, a new press_pulse follows after debounce.
